// File: rtl/jtframe_frame_dump.sv
// jtframe_frame_dump: video capture block for simulation and on-FPGA debug.
//
// Counts frames from VS leading edges. It selects a window of NFRAMES frames
// starting at frame START. Every visible pixel in that window is packed as
// {sof, sol, red, green, blue} and buffered in a FIFO with a valid/ready output.
//
// Ports:
//   clk, rst_n        single clock, synchronous active-low reset
//   pxl_cen           pixel clock enable
//   HS, VS, de        syncs (active level HSPOL/VSPOL) and display enable
//   red/green/blue    COLORW-bit colour channels
//   frame_cnt         VS leading edges seen since reset
//   dump_active       current frame lies inside the capture window
//   dout/dout_valid   registered FIFO head; popped when dout_ready is high
//   overflow          sticky, set when a pixel was dropped on a full FIFO
//   done              sticky, window passed and FIFO drained
//
// Optional feature (macro JTFRAME_FRAME_DUMP_CRC_EN): adds crc/crc_valid,
// a CRC-16/CCITT (0x1021, init 0xFFFF) of the pushed RGB words of each frame.
// crc_valid pulses on the VS leading edge that ends a frame in the window.

module jtframe_frame_dump #(
    parameter int unsigned COLORW  = 4,
    parameter int unsigned START   = 0,
    parameter int unsigned NFRAMES = 1,
    parameter int unsigned DEPTH   = 16,
    parameter bit          HSPOL   = 1'b0,
    parameter bit          VSPOL   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pxl_cen,
    input  logic                  HS,
    input  logic                  VS,
    input  logic                  de,
    input  logic [COLORW-1:0]     red,
    input  logic [COLORW-1:0]     green,
    input  logic [COLORW-1:0]     blue,
    output logic [31:0]           frame_cnt,
    output logic                  dump_active,
    output logic [3*COLORW+1:0]   dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  overflow,
    output logic                  done
`ifdef JTFRAME_FRAME_DUMP_CRC_EN
    ,
    output logic [15:0]           crc,
    output logic                  crc_valid
`endif
);

    localparam int unsigned DW = 3 * COLORW + 2;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [32:0] WIN_LO = 33'(START);
    localparam logic [32:0] WIN_NF = 33'(NFRAMES);
    localparam logic [32:0] WIN_HI = 33'(START) + 33'(NFRAMES);

    // Sync edge detection: two register stages, edge flag is high one cycle
    // after the input changes.
    logic vs_q, vs_qq, hs_q, hs_qq;
    logic vs_edge, hs_edge;

    logic [31:0]   frame_cnt_q, frame_cnt_d;
    logic          sof_pend_q, sof_pend_d;
    logic          sol_pend_q, sol_pend_d;
    logic          push;
    logic [DW-1:0] push_word;
    logic [32:0]   cnt33;
    logic          past_win;

    // FIFO storage and the registered output stage
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] occupancy;
    logic [DW-1:0] dout_q, dout_d;
    logic          dout_valid_q, dout_valid_d;
    logic          overflow_q, overflow_d;
    logic          done_q, done_d;
    logic          pop, full, wr_en, load;

    assign vs_edge = (vs_q == VSPOL) && (vs_qq != VSPOL);
    assign hs_edge = (hs_q == HSPOL) && (hs_qq != HSPOL);

    // Window compare in 33 bits. When cnt33 < WIN_LO the subtraction wraps to
    // at least 2^32, which always exceeds NFRAMES, so one compare covers both ends.
    assign cnt33       = {1'b0, frame_cnt_q};
    assign dump_active = (cnt33 - WIN_LO) < WIN_NF;
    assign past_win    = cnt33 >= WIN_HI;

    assign push      = pxl_cen && de && dump_active;
    assign push_word = {sof_pend_q, sol_pend_q, red, green, blue};

    // The output register counts as one FIFO entry.
    assign occupancy = count_q + CW'(dout_valid_q);
    assign full      = occupancy == CW'(DEPTH);
    assign pop       = dout_valid_q && dout_ready;
    assign wr_en     = push && (!full || pop);
    assign load      = (count_q != '0) && (!dout_valid_q || pop);

    always_comb begin
        frame_cnt_d  = frame_cnt_q;
        sof_pend_d   = sof_pend_q;
        sol_pend_d   = sol_pend_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overflow_d   = overflow_q;
        done_d       = done_q;

        if (vs_edge) frame_cnt_d = frame_cnt_q + 32'd1;

        // A sync edge arms the flag even if a pixel is pushed in the same
        // cycle; that pixel still belongs to the previous frame or line.
        if (push)    sof_pend_d = 1'b0;
        if (vs_edge) sof_pend_d = 1'b1;
        if (push)    sol_pend_d = 1'b0;
        if (hs_edge) sol_pend_d = 1'b1;

        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (load)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(wr_en) - CW'(load);

        if (load) begin
            dout_d       = mem[rd_ptr_q];
            dout_valid_d = 1'b1;
        end else if (pop) begin
            dout_valid_d = 1'b0;
        end

        if (push && full && !pop) overflow_d = 1'b1;
        if (past_win && (count_q == '0) && !dout_valid_q) done_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_q         <= !VSPOL;
            vs_qq        <= !VSPOL;
            hs_q         <= !HSPOL;
            hs_qq        <= !HSPOL;
            frame_cnt_q  <= '0;
            sof_pend_q   <= 1'b0;
            sol_pend_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            vs_q         <= VS;
            vs_qq        <= vs_q;
            hs_q         <= HS;
            hs_qq        <= hs_q;
            frame_cnt_q  <= frame_cnt_d;
            sof_pend_q   <= sof_pend_d;
            sol_pend_q   <= sol_pend_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            done_q       <= done_d;
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= push_word;
    end

    assign frame_cnt  = frame_cnt_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overflow   = overflow_q;
    assign done       = done_q;

`ifdef JTFRAME_FRAME_DUMP_CRC_EN
    logic [15:0] crc_acc_q, crc_acc_d;
    logic [15:0] crc_q, crc_d;
    logic        crc_valid_q, crc_valid_d;

    // Bit-serial CCITT update, MSB of {red, green, blue} first.
    function automatic logic [15:0] crc_step(input logic [15:0]         c,
                                             input logic [3*COLORW-1:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 3 * COLORW - 1; i >= 0; i--) begin
            r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    always_comb begin
        crc_acc_d   = crc_acc_q;
        crc_d       = crc_q;
        crc_valid_d = 1'b0;
        // Computed on every push, so dropped pixels are still covered.
        if (push) begin
            crc_acc_d = crc_step(sof_pend_q ? 16'hFFFF : crc_acc_q, {red, green, blue});
        end
        // Pre-update dump_active covers frames inside the window and the one
        // just leaving it, but not the edge that enters the window.
        if (vs_edge && dump_active) begin
            crc_valid_d = 1'b1;
            crc_d       = crc_acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_acc_q   <= 16'hFFFF;
            crc_q       <= '0;
            crc_valid_q <= 1'b0;
        end else begin
            crc_acc_q   <= crc_acc_d;
            crc_q       <= crc_d;
            crc_valid_q <= crc_valid_d;
        end
    end

    assign crc       = crc_q;
    assign crc_valid = crc_valid_q;
`endif

endmodule

// File: tb/tb_jtframe_frame_dump.sv
module tb_jtframe_frame_dump;

    localparam int unsigned CW = 4;
    localparam int unsigned DWID = 3 * CW + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the window DUT (a) and the inverted-polarity DUT (c)
    logic          rst_n, pxl_cen, hs, vs, de, ready_a;
    logic [CW-1:0] r, g, b;

    logic [31:0]     fc_a, fc_c, fc_b;
    logic            act_a, act_c, act_b;
    logic [DWID-1:0] dout_a, dout_c, dout_b;
    logic            val_a, val_c, val_b;
    logic            ovf_a, ovf_c, ovf_b;
    logic            done_a, done_c, done_b;

    // Back-pressure DUT (b)
    logic          rst_b, de_b, ready_b;
    logic [CW-1:0] r_b, g_b, b_b;

`ifdef JTFRAME_FRAME_DUMP_CRC_EN
    logic [15:0] crc_a, crc_b, crc_c;
    logic        crcv_a, crcv_b, crcv_c;
    int          crc_pulses = 0;
    logic [15:0] crc_seen = '0;
`endif

    jtframe_frame_dump #(.COLORW(CW), .START(2), .NFRAMES(1), .DEPTH(16),
                         .HSPOL(1'b0), .VSPOL(1'b0)) dut_a (
`ifdef JTFRAME_FRAME_DUMP_CRC_EN
        .crc(crc_a), .crc_valid(crcv_a),
`endif
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .HS(hs), .VS(vs), .de(de),
        .red(r), .green(g), .blue(b), .frame_cnt(fc_a), .dump_active(act_a),
        .dout(dout_a), .dout_valid(val_a), .dout_ready(ready_a),
        .overflow(ovf_a), .done(done_a));

    jtframe_frame_dump #(.COLORW(CW), .START(2), .NFRAMES(1), .DEPTH(16),
                         .HSPOL(1'b1), .VSPOL(1'b1)) dut_c (
`ifdef JTFRAME_FRAME_DUMP_CRC_EN
        .crc(crc_c), .crc_valid(crcv_c),
`endif
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .HS(~hs), .VS(~vs), .de(de),
        .red(r), .green(g), .blue(b), .frame_cnt(fc_c), .dump_active(act_c),
        .dout(dout_c), .dout_valid(val_c), .dout_ready(ready_a),
        .overflow(ovf_c), .done(done_c));

    jtframe_frame_dump #(.COLORW(CW), .START(0), .NFRAMES(1), .DEPTH(4),
                         .HSPOL(1'b0), .VSPOL(1'b0)) dut_b (
`ifdef JTFRAME_FRAME_DUMP_CRC_EN
        .crc(crc_b), .crc_valid(crcv_b),
`endif
        .clk(clk), .rst_n(rst_b), .pxl_cen(1'b1), .HS(1'b1), .VS(1'b1), .de(de_b),
        .red(r_b), .green(g_b), .blue(b_b), .frame_cnt(fc_b), .dump_active(act_b),
        .dout(dout_b), .dout_valid(val_b), .dout_ready(ready_b),
        .overflow(ovf_b), .done(done_b));

    // Sinks: record every accepted word, sampled mid-cycle.
    logic [DWID-1:0] qa[$], qb[$], qc[$];
    always @(negedge clk) begin
        if (val_a && ready_a) qa.push_back(dout_a);
        if (val_c && ready_a) qc.push_back(dout_c);
        if (val_b && ready_b) qb.push_back(dout_b);
`ifdef JTFRAME_FRAME_DUMP_CRC_EN
        if (crcv_a) begin
            crc_pulses++;
            crc_seen = crc_a;
        end
`endif
    end

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [DWID-1:0] word(input logic sof, input logic sol,
                                             input logic [CW-1:0] wr, input logic [CW-1:0] wg,
                                             input logic [CW-1:0] wb);
        return {sof, sol, wr, wg, wb};
    endfunction

    // One frame: VS pulse, then 2 lines of 4 visible pixels each.
    // red carries the frame index, green the line, blue the column.
    task automatic frame(input logic [CW-1:0] fid);
        vs = 1'b0; tick(2); vs = 1'b1; tick(3);
        for (int l = 0; l < 2; l++) begin
            hs = 1'b0; tick(1); hs = 1'b1; tick(2);
            for (int c = 0; c < 4; c++) begin
                de = 1'b1; r = fid; g = CW'(l + 5); b = CW'(c + 9);
                tick(1);
            end
            de = 1'b0; tick(2);
        end
    endtask

`ifdef JTFRAME_FRAME_DUMP_CRC_EN
    function automatic logic [15:0] crc_ref_step(input logic [15:0] c, input logic [11:0] d);
        logic [15:0] x;
        x = c;
        for (int i = 11; i >= 0; i--) begin
            if (x[15] ^ d[i]) x = {x[14:0], 1'b0} ^ 16'h1021;
            else              x = {x[14:0], 1'b0};
        end
        return x;
    endfunction
`endif

    initial begin
        logic [DWID-1:0] obs;
        logic [DWID-1:0] exp_w [8];
        logic [15:0]     crc_ref;

        rst_n = 1'b0; rst_b = 1'b0; pxl_cen = 1'b1; hs = 1'b1; vs = 1'b1; de = 1'b0;
        r = '0; g = '0; b = '0; ready_a = 1'b1;
        de_b = 1'b0; ready_b = 1'b0; r_b = '0; g_b = '0; b_b = '0;

        // Reset held while the syncs toggle
        repeat (3) begin
            tick(1);
            vs = ~vs; hs = ~hs;
        end
        vs = 1'b1; hs = 1'b1;
        tick(1);
        chk("reset frame_cnt", 64'(fc_a), 64'd0);
        chk("reset dout_valid", 64'(val_a), 64'd0);
        chk("reset overflow", 64'(ovf_a), 64'd0);
        chk("reset done", 64'(done_a), 64'd0);
        chk("reset dump_active start2", 64'(act_a), 64'd0);
        chk("reset dump_active start0", 64'(act_b), 64'd1);
        chk("reset dout", 64'(dout_a), 64'd0);
        rst_n = 1'b1; rst_b = 1'b1;
        tick(3);
        chk("idle frame_cnt", 64'(fc_a), 64'd0);

        // Window test: only frame 2 is captured
        frame(4'd1);
        tick(4);
        chk("frame1 frame_cnt", 64'(fc_a), 64'd1);
        chk("frame1 no words", 64'(qa.size()), 64'd0);
        frame(4'd2);
        tick(6);
        chk("frame2 frame_cnt", 64'(fc_a), 64'd2);
        chk("frame2 dump_active", 64'(act_a), 64'd1);
        chk("frame2 done low", 64'(done_a), 64'd0);
        chk("frame2 word count", 64'(qa.size()), 64'd8);
        frame(4'd3);
        tick(6);
        chk("frame3 frame_cnt", 64'(fc_a), 64'd3);
        chk("frame3 dump_active", 64'(act_a), 64'd0);
        chk("frame3 done", 64'(done_a), 64'd1);
        chk("frame3 word count", 64'(qa.size()), 64'd8);

        for (int i = 0; i < 8; i++) begin
            exp_w[i] = word(i == 0, (i % 4) == 0, 4'd2, CW'(i / 4 + 5), CW'(i % 4 + 9));
        end
        for (int i = 0; i < 8; i++) begin
            obs = (i < qa.size()) ? qa[i] : 'x;
            chk($sformatf("window word %0d", i), 64'(obs), 64'(exp_w[i]));
        end

        // Inverted sync polarity yields the same stream
        chk("pol frame_cnt", 64'(fc_c), 64'd3);
        chk("pol done", 64'(done_c), 64'd1);
        chk("pol word count", 64'(qc.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            obs = (i < qc.size()) ? qc[i] : 'x;
            chk($sformatf("pol word %0d", i), 64'(obs), 64'(exp_w[i]));
        end

`ifdef JTFRAME_FRAME_DUMP_CRC_EN
        crc_ref = 16'hFFFF;
        for (int i = 0; i < 8; i++) crc_ref = crc_ref_step(crc_ref, exp_w[i][11:0]);
        chk("crc pulse count", 64'(crc_pulses), 64'd1);
        chk("crc value", 64'(crc_seen), 64'(crc_ref));
`else
        crc_ref = '0;
`endif

        // Back-pressure on a 4-deep FIFO
        for (int k = 0; k < 4; k++) begin
            de_b = 1'b1; r_b = CW'(k + 1); g_b = CW'(k + 3); b_b = CW'(k + 7);
            tick(1);
        end
        de_b = 1'b0;
        tick(3);
        chk("bp valid", 64'(val_b), 64'd1);
        chk("bp head", 64'(dout_b), 64'(word(1'b0, 1'b0, 4'd1, 4'd3, 4'd7)));
        chk("bp no overflow", 64'(ovf_b), 64'd0);
        tick(3);
        chk("bp head stable", 64'(dout_b), 64'(word(1'b0, 1'b0, 4'd1, 4'd3, 4'd7)));
        de_b = 1'b1; r_b = 4'd15; g_b = 4'd15; b_b = 4'd15;
        tick(1);
        de_b = 1'b0;
        tick(1);
        chk("bp overflow", 64'(ovf_b), 64'd1);
        ready_b = 1'b1;
        tick(8);
        ready_b = 1'b0;
        chk("bp drained", 64'(val_b), 64'd0);
        chk("bp word count", 64'(qb.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            obs = (k < qb.size()) ? qb[k] : 'x;
            chk($sformatf("bp word %0d", k), 64'(obs),
                64'(word(1'b0, 1'b0, CW'(k + 1), CW'(k + 3), CW'(k + 7))));
        end

        // Full FIFO with push and pop in the same cycle
        rst_b = 1'b0;
        tick(1);
        rst_b = 1'b1;
        qb.delete();
        chk("fp overflow cleared", 64'(ovf_b), 64'd0);
        for (int k = 0; k < 4; k++) begin
            de_b = 1'b1; r_b = CW'(k + 8); g_b = CW'(k); b_b = CW'(15 - k);
            tick(1);
        end
        de_b = 1'b1; r_b = 4'd12; g_b = 4'd4; b_b = 4'd11; ready_b = 1'b1;
        tick(1);
        de_b = 1'b0; ready_b = 1'b0;
        tick(2);
        chk("fp no overflow", 64'(ovf_b), 64'd0);
        // Still full: one more push must be dropped
        de_b = 1'b1; r_b = 4'd0; g_b = 4'd0; b_b = 4'd0;
        tick(1);
        de_b = 1'b0;
        tick(1);
        chk("fp still full", 64'(ovf_b), 64'd1);
        ready_b = 1'b1;
        tick(8);
        ready_b = 1'b0;
        chk("fp word count", 64'(qb.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            obs = (k < qb.size()) ? qb[k] : 'x;
            chk($sformatf("fp word %0d", k), 64'(obs),
                64'(word(1'b0, 1'b0, CW'(k + 8), CW'(k), CW'(15 - k))));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
